// File: rtl/sn_serial_byte_tx_pkg.sv
// ---------------------------------------------------------------------------
// sn76489_pkg: shared types and constants for the SN76489 serial byte path.
//   tx_state_t   - transmitter FSM states
//   BYTE_W       - serialized word width
//   BIT_CNT_W    - width of the bit-within-byte counter
//   div_width()  - divider width for a given bit period (at least 1 bit)
// ---------------------------------------------------------------------------
package sn76489_pkg;

    typedef enum logic [1:0] {TX_IDLE, TX_SHIFT, TX_DONE} tx_state_t;

    localparam int BYTE_W    = 8;
    localparam int BIT_CNT_W = 3;

    function automatic int div_width(input int clks_per_bit);
        return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
    endfunction

endpackage

// File: rtl/sn_serial_byte_tx_if.sv
// ---------------------------------------------------------------------------
// sn_serial_byte_tx_if: valid/ready word handshake into the serial transmitter.
//   TX_VALID - producer has a word on TX_DATA
//   TX_DATA  - word to send (sampled on the accept cycle only)
//   TX_READY - transmitter can take a word this cycle
// Modports: master (producer side), slave (transmitter side).
// ---------------------------------------------------------------------------
interface sn_serial_byte_tx_if;
    import sn76489_pkg::*;

    logic              TX_VALID;
    logic [BYTE_W-1:0] TX_DATA;
    logic              TX_READY;

    modport master (output TX_VALID, output TX_DATA, input TX_READY);
    modport slave  (input TX_VALID, input TX_DATA, output TX_READY);

endinterface

// File: rtl/sn_serial_byte_tx_piso.sv
// ---------------------------------------------------------------------------
// sn_piso_shift: 8-bit parallel-in / serial-out register, shifting right
// with zero fill so the LSB leaves first.
//   CLK, nRST - clock, async active-low reset (clears the register)
//   LOAD, D   - parallel load; LOAD wins over SHIFT
//   SHIFT     - shift right by one
//   BIT_OUT   - current LSB
// ---------------------------------------------------------------------------
module sn_piso_shift
    import sn76489_pkg::*;
(
    input  logic              CLK,
    input  logic              nRST,
    input  logic              LOAD,
    input  logic [BYTE_W-1:0] D,
    input  logic              SHIFT,
    output logic              BIT_OUT
);

    logic [BYTE_W-1:0] shreg_q, shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (LOAD)       shreg_d = D;
        else if (SHIFT) shreg_d = {1'b0, shreg_q[BYTE_W-1:1]};
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) shreg_q <= '0;
        else       shreg_q <= shreg_d;
    end

    assign BIT_OUT = shreg_q[0];

endmodule

// File: rtl/sn_serial_byte_tx.sv
// ---------------------------------------------------------------------------
// sn_serial_byte_tx: accepts one byte over a valid/ready handshake and sends
// it LSB-first on BIT_OUT, each bit held CLKS_PER_BIT cycles.
//   CLK, nRST  - clock, async active-low reset (aborts any transfer)
//   tx         - slave side of the word handshake
//   BIT_OUT    - serial data, 0 when not shifting
//   SHIFT_EN   - one-cycle strobe on the last cycle of each bit period
//   BYTE_DONE  - one-cycle pulse after the eighth strobe
//   BUSY       - transfer in progress
// TX_READY is decoded from state only, so there is no VALID->READY path.
// ---------------------------------------------------------------------------
module sn_serial_byte_tx
    import sn76489_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
)(
    input  logic               CLK,
    input  logic               nRST,
    sn_serial_byte_tx_if.slave tx,
    output logic               BIT_OUT,
    output logic               SHIFT_EN,
    output logic               BYTE_DONE,
    output logic               BUSY
);

    localparam int                DIV_W    = div_width(CLKS_PER_BIT);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

    tx_state_t            state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_CNT_W-1:0] cnt_q, cnt_d;
    logic                 tx_ready;
    logic                 accept;
    logic                 bit_last;
    logic                 piso_bit;

    assign accept   = tx.TX_VALID && (state_q == TX_IDLE);
    assign bit_last = (div_q == DIV_LAST);

    // State register and counters
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= TX_IDLE;
            div_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state and counter updates
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        cnt_d   = cnt_q;
        case (state_q)
            TX_IDLE: begin
                if (accept) begin
                    state_d = TX_SHIFT;
                    div_d   = '0;
                    cnt_d   = '0;
                end
            end
            TX_SHIFT: begin
                if (bit_last) begin
                    div_d = '0;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == BIT_CNT_W'(BYTE_W - 1)) state_d = TX_DONE;
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            TX_DONE: state_d = TX_IDLE;
            default: state_d = TX_IDLE;
        endcase
    end

    // Outputs decoded from registered state
    always_comb begin
        tx_ready  = 1'b0;
        BIT_OUT   = 1'b0;
        SHIFT_EN  = 1'b0;
        BYTE_DONE = 1'b0;
        BUSY      = 1'b1;
        case (state_q)
            TX_IDLE: begin
                tx_ready = 1'b1;
                BUSY     = 1'b0;
            end
            TX_SHIFT: begin
                BIT_OUT  = piso_bit;
                SHIFT_EN = bit_last;
            end
            TX_DONE:  BYTE_DONE = 1'b1;
            default:  BUSY = 1'b0;
        endcase
    end

    assign tx.TX_READY = tx_ready;

    sn_piso_shift u_piso (
        .CLK     (CLK),
        .nRST    (nRST),
        .LOAD    (accept),
        .D       (tx.TX_DATA),
        .SHIFT   (SHIFT_EN),
        .BIT_OUT (piso_bit)
    );

endmodule

// File: tb/tb_sn_serial_byte_tx.sv
// ---------------------------------------------------------------------------
// Bench for sn_serial_byte_tx. Four instances with CLKS_PER_BIT = 1,3,4,7
// share clock and reset. Expected outputs for each cycle of a transfer are
// computed from the accept edge with plain arithmetic, and a reference
// {DATA_IN, reg[7:1]} deserializer clocked by SHIFT_EN reassembles the byte.
// ---------------------------------------------------------------------------
module tb_sn_serial_byte_tx;

    logic       CLK = 1'b0;
    logic       nRST;
    logic [3:0] valid_a;
    logic [7:0] data_a [4];
    wire  [3:0] ready_a, bit_a, sen_a, done_a, busy_a;

    int ncmp  = 0;
    int nfail = 0;

    always #5 CLK = ~CLK;

    function automatic int cpb(input int i);
        case (i)
            0:       return 1;
            1:       return 3;
            2:       return 4;
            default: return 7;
        endcase
    endfunction

    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int C = (g == 0) ? 1 : (g == 1) ? 3 : (g == 2) ? 4 : 7;
        sn_serial_byte_tx_if u_if ();
        assign u_if.TX_VALID = valid_a[g];
        assign u_if.TX_DATA  = data_a[g];
        assign ready_a[g]    = u_if.TX_READY;
        sn_serial_byte_tx #(.CLKS_PER_BIT(C)) u_dut (
            .CLK       (CLK),
            .nRST      (nRST),
            .tx        (u_if),
            .BIT_OUT   (bit_a[g]),
            .SHIFT_EN  (sen_a[g]),
            .BYTE_DONE (done_a[g]),
            .BUSY      (busy_a[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input int i, input string tag);
        chk({tag, " TX_READY"},  32'(ready_a[i]), 1);
        chk({tag, " BUSY"},      32'(busy_a[i]),  0);
        chk({tag, " BIT_OUT"},   32'(bit_a[i]),   0);
        chk({tag, " SHIFT_EN"},  32'(sen_a[i]),   0);
        chk({tag, " BYTE_DONE"}, 32'(done_a[i]),  0);
    endtask

    // Called just after a falling edge. Offers byte d, waits for the accept
    // edge, then checks every cycle of the transfer. hold keeps VALID high
    // with nxt on TX_DATA for a back-to-back send; scrib drives junk with
    // VALID during SHIFT; abort_t>0 asserts reset at that cycle.
    task automatic send(input int i, input logic [7:0] d, input bit hold,
                        input logic [7:0] nxt, input bit scrib,
                        input int abort_t, output time t_acc);
        int         c = cpb(i);
        int         guard = 0;
        int         nsen = 0;
        logic [7:0] rx = 8'h00;
        logic       e_busy, e_bit, e_sen, e_done;
        string      tg;
        valid_a[i] = 1'b1;
        data_a[i]  = d;
        t_acc      = 0;
        while (ready_a[i] !== 1'b1 && guard < 100) begin
            @(negedge CLK);
            guard++;
        end
        if (ready_a[i] !== 1'b1) begin
            chk($sformatf("cpb%0d accept timeout", c), 32'(ready_a[i]), 1);
            valid_a[i] = 1'b0;
            return;
        end
        @(posedge CLK);
        t_acc = $time;
        for (int t = 1; t <= 8 * c + 2; t++) begin
            @(negedge CLK);
            if (t == 1) begin
                if (hold) data_a[i] = nxt;
                else      valid_a[i] = 1'b0;
            end
            if (scrib) begin
                if (t == 3)     begin data_a[i] = 8'hFF; valid_a[i] = 1'b1; end
                if (t == 8 * c) valid_a[i] = 1'b0;
            end
            e_busy = (t <= 8 * c + 1);
            e_bit  = (t <= 8 * c) ? d[(t - 1) / c] : 1'b0;
            e_sen  = (t <= 8 * c) && (t % c == 0);
            e_done = (t == 8 * c + 1);
            tg = $sformatf("cpb%0d d%02h t%0d", c, d, t);
            chk({tg, " BIT_OUT"},   32'(bit_a[i]),   32'(e_bit));
            chk({tg, " SHIFT_EN"},  32'(sen_a[i]),   32'(e_sen));
            chk({tg, " BYTE_DONE"}, 32'(done_a[i]),  32'(e_done));
            chk({tg, " BUSY"},      32'(busy_a[i]),  32'(e_busy));
            chk({tg, " TX_READY"},  32'(ready_a[i]), 32'(!e_busy));
            if (t == abort_t) begin
                nRST = 1'b0;
                #1;
                check_idle(i, {tg, " async reset"});
                valid_a[i] = 1'b0;
                return;
            end
            if (sen_a[i] === 1'b1) begin
                rx = {bit_a[i], rx[7:1]};
                nsen++;
            end
            if (done_a[i] === 1'b1) chk({tg, " rx byte"}, 32'(rx), 32'(d));
        end
        chk($sformatf("cpb%0d d%02h strobe count", c, d), nsen, 8);
    endtask

    initial begin
        time t1, t2;
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        time ta, tb;
        nRST    = 1'b0;
        valid_a = 4'h0;
        for (int i = 0; i < 4; i++) data_a[i] = 8'h00;

        // Reset state, inputs ignored while in reset
        valid_a = 4'hF;
        repeat (3) @(negedge CLK);
        for (int i = 0; i < 4; i++) check_idle(i, $sformatf("in reset cpb%0d", cpb(i)));
        valid_a = 4'h0;
        nRST = 1'b1;

        // Idle for 10 cycles
        for (int n = 0; n < 10; n++) begin
            @(negedge CLK);
            for (int i = 0; i < 4; i++) check_idle(i, $sformatf("idle n%0d cpb%0d", n, cpb(i)));
        end

        // CLKS_PER_BIT=4, 8'hA5
        send(2, 8'hA5, 1'b0, 8'h00, 1'b0, 0, ta);

        // CLKS_PER_BIT=1, back-to-back 8'h01 then 8'h80
        send(0, 8'h01, 1'b1, 8'h80, 1'b0, 0, ta);
        send(0, 8'h80, 1'b0, 8'h00, 1'b0, 0, tb);
        chk("b2b accept spacing", 32'((tb - ta) / 10), 10);

        // TX_DATA/TX_VALID activity during SHIFT has no effect
        send(2, 8'h3C, 1'b0, 8'h00, 1'b1, 0, ta);
        @(negedge CLK);
        check_idle(2, "after scribble");

        // Reset during bit 4 of 8'hC3
        send(2, 8'hC3, 1'b0, 8'h00, 1'b0, 18, ta);
        for (int n = 0; n < 3; n++) begin
            @(negedge CLK);
            check_idle(2, $sformatf("held reset n%0d", n));
        end
        nRST = 1'b1;
        send(2, 8'h5A, 1'b0, 8'h00, 1'b0, 0, ta);

        // Other bit periods
        send(1, 8'h96, 1'b0, 8'h00, 1'b0, 0, ta);
        send(3, 8'h69, 1'b0, 8'h00, 1'b0, 0, ta);

        // Random bytes on random instances
        for (int n = 0; n < 12; n++) begin
            int         i   = int'($urandom_range(0, 3));
            int         gap = int'($urandom_range(0, 3));
            logic [7:0] d   = 8'($urandom);
            for (int g = 0; g < gap; g++) begin
                @(negedge CLK);
                check_idle(i, $sformatf("rand gap n%0d", n));
            end
            send(i, d, 1'b0, 8'h00, 1'b0, 0, ta);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
